debug_console_monitor: RTL and testbench

- Synthesizable, multi-channel successor to the bench-only console/stop monitor for hf_riscv.
- Snoops the processor-peripheral bus and captures character writes to NUM_CH console addresses into one tagged FIFO, inserting newlines at LINE_MAX columns.
- Flags end-of-simulation, out-of-region accesses and IRQ-vector fetches as registered status.
- Sits beside the core on the peripheral bus. Drained by a bench, a UART or a host bridge via valid/ready.

---
 rtl/debug_console_monitor.sv | 272 +++++++++++++++++++++++++++
 tb/tb_debug_console_monitor.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_console_monitor.sv
// Generic FIFO: circular buffer with count-based full/empty and a directly exposed head entry.
// Latency: a write into an empty FIFO is visible on rd_vld the next cycle.
// Backpressure: wr_rdy drops when full unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     wr_rdy,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW:0]      cnt_q;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full   = (cnt_q == (AW+1)'(DEPTH));
    assign rd_vld = (cnt_q != '0);
    assign do_rd  = rd_vld & rd_rdy;
    assign wr_rdy = ~full | do_rd;
    assign do_wr  = wr_vld & wr_rdy;
    assign rd_dat = mem_q[rd_ptr_q];
    assign level  = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_dat;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// Console snooper: captures console writes per channel into a tagged FIFO with forced line wrap, plus sticky bus status.
// Latency: a captured character appears on out_valid one cycle after its strobe edge; status is visible one cycle after the access.
// Backpressure: out_valid/out_ready on the FIFO head; when full, new entries are dropped and overflow is set.
module debug_console_monitor #(
    parameter int          NUM_CH       = 2,
    parameter logic [31:0] CONSOLE_ADDR = 32'hf00000d0,
    parameter logic [31:0] STOP_ADDR    = 32'he0000000,
    parameter logic [31:0] REGION_LO    = 32'h50000000,
    parameter logic [31:0] REGION_HI    = 32'he0000000,
    parameter logic [31:0] IRQ_ADDR     = 32'h40000104,
    parameter int          CHAR_LSB     = 24,
    parameter int          LINE_MAX     = 72,
    parameter int          FIFO_DEPTH   = 16,
    localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int         LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              bus_req,
    input  logic [31:0]       address,
    input  logic              data_we,
    input  logic [31:0]       data_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_char,
    output logic [CH_W-1:0]   out_ch,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    output logic              sim_done,
    output logic              region_err,
    output logic [31:0]       err_addr,
    output logic              irq_seen
);
    localparam int              COL_W    = (LINE_MAX > 2) ? $clog2(LINE_MAX) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_MAX - 1);
    localparam logic [7:0]      NL_CHAR  = 8'h0a;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [7:0]      chr;
    } ent_t;

    typedef enum logic {
        S_IDLE,
        S_PUSH_NL
    } state_t;

    state_t           state_q, state_d;
    logic [NUM_CH-1:0] hit, hit_q, rise;
    logic [COL_W-1:0] col_q [NUM_CH];
    logic [COL_W-1:0] col_d [NUM_CH];
    logic             hold_vld_q, hold_vld_d;
    ent_t             hold_q, hold_d;
    logic [CH_W-1:0]  nl_ch_q, nl_ch_d;
    ent_t             cap;
    logic             cap_vld;
    ent_t             proc;
    logic             proc_vld;
    logic             push_vld;
    ent_t             push_dat;
    logic             drop;
    logic             fifo_wr_rdy;
    ent_t             head;
    logic             in_region;
    logic             unused_data_bits;

    assign unused_data_bits = ^(data_write & ~(32'h7f << CHAR_LSB));

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = bus_req & data_we & (address == CONSOLE_ADDR + 32'(4 * i));
        end
    end

    // One capture per rising edge of a channel's strobe; the address selects at most one channel.
    assign rise    = hit & ~hit_q;
    assign cap_vld = |rise;

    always_comb begin
        cap     = '0;
        cap.chr = {1'b0, data_write[CHAR_LSB+6:CHAR_LSB]};
        for (int i = 0; i < NUM_CH; i++) begin
            if (rise[i]) begin
                cap.ch = CH_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_vld_d = hold_vld_q;
        hold_d     = hold_q;
        nl_ch_d    = nl_ch_q;
        col_d      = col_q;
        proc_vld   = 1'b0;
        proc       = '0;
        push_vld   = 1'b0;
        push_dat   = '0;
        drop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A held capture is older than anything arriving now, so it goes first.
                if (hold_vld_q) begin
                    proc_vld   = 1'b1;
                    proc       = hold_q;
                    hold_vld_d = cap_vld;
                    if (cap_vld) begin
                        hold_d = cap;
                    end
                end else if (cap_vld) begin
                    proc_vld = 1'b1;
                    proc     = cap;
                end
            end
            S_PUSH_NL: begin
                push_vld     = 1'b1;
                push_dat.ch  = nl_ch_q;
                push_dat.chr = NL_CHAR;
                state_d      = S_IDLE;
                if (cap_vld) begin
                    if (hold_vld_q) begin
                        drop = 1'b1;
                    end else begin
                        hold_vld_d = 1'b1;
                        hold_d     = cap;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Column tracking happens as the character enters the FIFO path, whether or not the FIFO has room.
        if (proc_vld) begin
            push_vld = 1'b1;
            push_dat = proc;
            if (proc.chr == NL_CHAR) begin
                col_d[proc.ch] = '0;
            end else if (col_q[proc.ch] == COL_LAST) begin
                col_d[proc.ch] = '0;
                state_d        = S_PUSH_NL;
                nl_ch_d        = proc.ch;
            end else begin
                col_d[proc.ch] = col_q[proc.ch] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            hit_q      <= '0;
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
            nl_ch_q    <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                col_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hit_q      <= hit;
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
            nl_ch_q    <= nl_ch_d;
            col_q      <= col_d;
            overflow   <= overflow | drop | (push_vld & ~fifo_wr_rdy);
        end
    end

    sync_fifo #(
        .WIDTH ($bits(ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clock_in),
        .rst_n  (reset_n),
        .wr_vld (push_vld),
        .wr_dat (push_dat),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (head),
        .level  (fifo_level)
    );

    assign out_char = head.chr;
    assign out_ch   = head.ch;

    assign in_region = (address >= REGION_LO) && (address < REGION_HI);

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sim_done   <= 1'b0;
            region_err <= 1'b0;
            err_addr   <= '0;
            irq_seen   <= 1'b0;
        end else begin
            irq_seen <= bus_req & (address == IRQ_ADDR);
            if (bus_req) begin
                if (address == STOP_ADDR) begin
                    sim_done <= 1'b1;
                end
                if (in_region) begin
                    region_err <= 1'b1;
                    if (!region_err) begin
                        err_addr <= address;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_debug_console_monitor.sv
// Bench for debug_console_monitor: directed console/status sequences plus a randomized console stream
// checked against a per-channel column model.
module tb_debug_console_monitor;
    localparam logic [31:0] CON = 32'hf00000d0;
    localparam int          LINE_MAX = 72;

    logic        clock_in = 1'b0;
    logic        reset_n  = 1'b0;
    logic        bus_req  = 1'b0;
    logic [31:0] address  = '0;
    logic        data_we  = 1'b0;
    logic [31:0] data_write = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_char;
    logic [0:0]  out_ch;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        sim_done;
    logic        region_err;
    logic [31:0] err_addr;
    logic        irq_seen;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];
    int mcol[2];

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        region;
        logic [31:0] eaddr;
        logic        sim;
        logic        irq;
    } svec_t;
    svec_t tbl[9];

    debug_console_monitor dut (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .bus_req    (bus_req),
        .address    (address),
        .data_we    (data_we),
        .data_write (data_write),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_char   (out_char),
        .out_ch     (out_ch),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .sim_done   (sim_done),
        .region_err (region_err),
        .err_addr   (err_addr),
        .irq_seen   (irq_seen)
    );

    always #5 clock_in = ~clock_in;

    always @(negedge clock_in) begin
        if (reset_n && out_valid && out_ready) got.push_back({out_ch, out_char});
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic apply_reset();
        bus_req = 0; data_we = 0; address = 0; data_write = 0; out_ready = 0;
        #2 reset_n = 0;
        #10 reset_n = 1;
        step();
        got.delete();
        exp_q.delete();
    endtask

    task automatic drive_char(int ch, logic [6:0] c);
        bus_req = 1; data_we = 1;
        address = CON + 32'(4 * ch);
        data_write = $urandom;
        data_write[30:24] = c;
    endtask

    task automatic go_idle();
        bus_req = 0; data_we = 0;
        address = $urandom;
        data_write = $urandom;
    endtask

    task automatic strobe(int ch, logic [6:0] c);
        drive_char(ch, c);
        step();
    endtask

    task automatic write_char(int ch, logic [6:0] c, int gap);
        strobe(ch, c);
        go_idle();
        repeat (gap) step();
    endtask

    task automatic expect_ent(int ch, logic [6:0] c);
        exp_q.push_back({ch[0], 1'b0, c});
    endtask

    // Output stream rule: every accepted char in order, with a newline inserted right after
    // the LINE_MAX-th non-newline character of a line on that channel.
    task automatic model_write(int ch, logic [6:0] c);
        expect_ent(ch, c);
        if (c == 7'h0a) mcol[ch] = 0;
        else if (mcol[ch] + 1 == LINE_MAX) begin
            mcol[ch] = 0;
            expect_ent(ch, 7'h0a);
        end else mcol[ch] = mcol[ch] + 1;
    endtask

    task automatic compare_stream(string name);
        int cyc;
        cyc = 0;
        out_ready = 1;
        while ((got.size() < exp_q.size() || fifo_level != 0) && cyc < 2000) begin
            step();
            cyc++;
        end
        check({name, " count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) check(name, 32'(got[i]), 32'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [6:0] c;
        int ch;

        tbl[0] = '{1'b1, 32'h4fffffff, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'h60000000, 1'b1, 32'h60000000, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 32'h70000000, 1'b1, 32'h60000000, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'h40000104, 1'b1, 32'h60000000, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 32'he0000000, 1'b1, 32'h60000000, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 32'h40000104, 1'b1, 32'h60000000, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 32'h50000000, 1'b1, 32'h60000000, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 32'h40000104, 1'b1, 32'h60000000, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 32'h4fffffff, 1'b1, 32'h60000000, 1'b1, 1'b0};

        // Reset state
        apply_reset();
        check("rst out_valid", out_valid, 0);
        check("rst fifo_level", fifo_level, 0);
        check("rst overflow", overflow, 0);
        check("rst sim_done", sim_done, 0);
        check("rst region_err", region_err, 0);
        check("rst err_addr", err_addr, 0);
        check("rst irq_seen", irq_seen, 0);
        check("rst out_char", out_char, 0);
        check("rst out_ch", out_ch, 0);

        // Held strobe gives one entry, visible right after the strobe edge
        drive_char(0, 7'h48);
        data_write = 32'h48000000;
        step();
        check("H out_valid", out_valid, 1);
        check("H out_char", out_char, 8'h48);
        check("H out_ch", out_ch, 0);
        check("H level", fifo_level, 1);
        step();
        step();
        check("H held level", fifo_level, 1);
        go_idle();
        step();
        out_ready = 1;
        step();
        check("H drained level", fifo_level, 0);
        check("H drained valid", out_valid, 0);

        // Line wrap on channel 0, channel 1 column independent
        apply_reset();
        out_ready = 1;
        for (int i = 0; i < 72; i++) begin
            c = 7'(8'h61 + i % 26);
            expect_ent(0, c);
            write_char(0, c, 1);
        end
        expect_ent(0, 7'h0a);
        expect_ent(0, 7'h5a); write_char(0, 7'h5a, 1);
        expect_ent(1, 7'h79); write_char(1, 7'h79, 1);
        for (int i = 0; i < 71; i++) begin
            expect_ent(0, 7'h2e);
            write_char(0, 7'h2e, 1);
        end
        expect_ent(0, 7'h0a);
        expect_ent(1, 7'h7a); write_char(1, 7'h7a, 1);
        compare_stream("wrap stream");
        check("wrap overflow", overflow, 0);

        // Wrap on ch0 with ch1 capture during the newline cycle
        apply_reset();
        out_ready = 1;
        for (int i = 0; i < 71; i++) begin
            expect_ent(0, 7'h61);
            write_char(0, 7'h61, 1);
        end
        strobe(0, 7'h41);
        strobe(1, 7'h42);
        go_idle();
        step();
        expect_ent(0, 7'h41); expect_ent(0, 7'h0a); expect_ent(1, 7'h42);
        compare_stream("interleave stream");
        check("interleave overflow", overflow, 0);

        // Holding register full: fourth back-to-back capture is dropped
        apply_reset();
        out_ready = 1;
        for (int i = 0; i < 71; i++) begin
            expect_ent(0, 7'h61); write_char(0, 7'h61, 1);
            expect_ent(1, 7'h62); write_char(1, 7'h62, 1);
        end
        strobe(0, 7'h41);
        strobe(1, 7'h42);
        strobe(0, 7'h43);
        strobe(1, 7'h44);
        go_idle();
        step();
        expect_ent(0, 7'h41); expect_ent(0, 7'h0a);
        expect_ent(1, 7'h42); expect_ent(1, 7'h0a);
        expect_ent(0, 7'h43);
        compare_stream("holddrop stream");
        check("holddrop overflow", overflow, 1);

        // FIFO full with no consumer
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            if (i < 16) expect_ent(0, 7'(8'h41 + i));
            write_char(0, 7'(8'h41 + i), 1);
        end
        check("full level", fifo_level, 16);
        check("full overflow", overflow, 1);
        check("full head char", out_char, 8'h41);
        check("full out_valid", out_valid, 1);
        compare_stream("full stream");
        check("full drained level", fifo_level, 0);

        // Status table
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            bus_req = tbl[i].req;
            address = tbl[i].addr;
            data_we = 0;
            step();
            check($sformatf("status%0d region_err", i), region_err, tbl[i].region);
            check($sformatf("status%0d err_addr", i), err_addr, tbl[i].eaddr);
            check($sformatf("status%0d sim_done", i), sim_done, tbl[i].sim);
            check($sformatf("status%0d irq_seen", i), irq_seen, tbl[i].irq);
        end
        go_idle();
        step();
        check("status fifo_level", fifo_level, 0);
        check("status irq cleared", irq_seen, 0);

        // Async reset mid-drain
        apply_reset();
        bus_req = 1; address = 32'h60000000; step();
        address = STOP_ADDR_TB(); step();
        go_idle();
        for (int i = 0; i < 8; i++) write_char(1, 7'(8'h30 + i), 1);
        check("mid level 8", fifo_level, 8);
        out_ready = 1;
        repeat (3) step();
        check("mid level 5", fifo_level, 5);
        #2 reset_n = 0;
        #1;
        check("async out_valid", out_valid, 0);
        check("async level", fifo_level, 0);
        check("async sim_done", sim_done, 0);
        check("async region_err", region_err, 0);
        check("async err_addr", err_addr, 0);
        check("async overflow", overflow, 0);
        #4 reset_n = 1;
        step();
        got.delete();

        // Randomized console stream
        apply_reset();
        mcol[0] = 0;
        mcol[1] = 0;
        out_ready = 1;
        for (int n = 0; n < 600; n++) begin
            ch = $urandom_range(0, 1);
            c = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 15) == 0) c = 7'h0a;
            model_write(ch, c);
            write_char(ch, c, $urandom_range(1, 3));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        compare_stream("random stream");
        check("random overflow", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic [31:0] STOP_ADDR_TB();
        return 32'he0000000;
    endfunction
endmodule
